// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning the architectural HI/LO registers.
// Latency: MUL_LAT busy cycles (multiply) or WIDTH busy cycles (divide), then one DONE cycle; MTHI/MTLO take one cycle.
// Backpressure: stallE freezes F/D/E from the accepting cycle through the last busy cycle; it drops in DONE or on flushE.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   startE, opE     valid md op in E and its code (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   srcaE, srcbE    rs / rt operands
//   flushE          abort any in-flight op and block new starts
//   stallE, busy    pipeline stall request, FSM-not-idle indication
//   hi, lo          architectural HI / LO registers
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic [2:0]       opE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             flushE,
    output logic             stallE,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    // opReg[1] = divide, opReg[0] = unsigned
    logic [1:0]       opReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] cnt;

    // ---------------- start decode ----------------
    logic             mdStart;
    logic             mtStart;
    logic             startSigned;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    always_comb begin
        mdStart     = startE & ~opE[2] & ~flushE;
        mtStart     = startE & opE[2] & ~opE[1] & ~flushE;
        startSigned = ~opE[0];
        absA        = (startSigned & srcaE[WIDTH-1]) ? (~srcaE + 1'b1) : srcaE;
        absB        = (startSigned & srcbE[WIDTH-1]) ? (~srcbE + 1'b1) : srcbE;
    end

    always_comb begin
        stallE = ((state == IDLE) & mdStart) | ((state == BUSY) & ~flushE);
        busy   = (state != IDLE);
    end

    // ---------------- restoring divide step ----------------
    // The dividend magnitude sits in quo and is shifted out MSB-first while
    // quotient bits shift in at the bottom.
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;
    logic             remGe;
    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quoNext;

    always_comb begin
        remShift = {rem, quo[WIDTH-1]};
        diff     = remShift - {1'b0, dvs};
        // A set top bit of remShift already exceeds any divisor; otherwise the
        // top bit of diff is the borrow of the subtraction.
        remGe    = remShift[WIDTH] | ~diff[WIDTH];
        remNext  = remGe ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];
        quoNext  = {quo[WIDTH-2:0], remGe};
    end

    // ---------------- result formation (used in DONE) ----------------
    logic               resSigned;
    logic [2*WIDTH-1:0] extA;
    logic [2*WIDTH-1:0] extB;
    logic [2*WIDTH-1:0] prod;
    logic               negQ;
    logic               negR;
    logic               divZero;
    logic [WIDTH-1:0]   resHi;
    logic [WIDTH-1:0]   resLo;

    always_comb begin
        resSigned = ~opReg[0];
        // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of an unsigned
        // product equal to the signed product.
        extA      = {{WIDTH{resSigned & aReg[WIDTH-1]}}, aReg};
        extB      = {{WIDTH{resSigned & bReg[WIDTH-1]}}, bReg};
        prod      = extA * extB;
        negQ      = resSigned & (aReg[WIDTH-1] ^ bReg[WIDTH-1]);
        negR      = resSigned & aReg[WIDTH-1];
        divZero   = (bReg == '0);
        resHi     = prod[2*WIDTH-1:WIDTH];
        resLo     = prod[WIDTH-1:0];
        if (opReg[1]) begin
            if (divZero) begin
                resLo = '1;
                resHi = aReg;
            end else begin
                // MIN / -1 falls out naturally: magnitude quotient 2^(W-1)
                // negates back to MIN, remainder 0.
                resLo = negQ ? (~quo + 1'b1) : quo;
                resHi = negR ? (~rem + 1'b1) : rem;
            end
        end
    end

    // ---------------- state, operands, HI/LO ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opReg <= '0;
            aReg  <= '0;
            bReg  <= '0;
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdStart) begin
                        state <= BUSY;
                        opReg <= opE[1:0];
                        aReg  <= srcaE;
                        bReg  <= srcbE;
                        quo   <= absA;
                        rem   <= '0;
                        dvs   <= absB;
                        cnt   <= opE[1] ? CNT_W'(WIDTH - 1) : CNT_W'(MUL_LAT - 1);
                    end else if (mtStart) begin
                        if (opE[0]) begin
                            lo <= srcaE;
                        end else begin
                            hi <= srcaE;
                        end
                    end
                end
                BUSY: begin
                    if (flushE) begin
                        state <= IDLE;
                    end else begin
                        if (opReg[1]) begin
                            quo <= quoNext;
                            rem <= remNext;
                        end
                        if (cnt == '0) begin
                            state <= DONE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // The issuing instruction is still in E here, so startE
                    // is deliberately not looked at.
                    state <= IDLE;
                    if (!flushE) begin
                        hi <= resHi;
                        lo <= resLo;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        startE;
    logic [2:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        flushE;
    logic        stallE;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .startE (startE),
        .opE    (opE),
        .srcaE  (srcaE),
        .srcbE  (srcbE),
        .flushE (flushE),
        .stallE (stallE),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expStall;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one md op and hold it in E until stallE drops (DONE), then retire
    // it and wait for the HI/LO write edge.
    task automatic doOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls);
        @(negedge clk);
        startE = 1'b1;
        opE    = op;
        srcaE  = a;
        srcbE  = b;
        stalls = 0;
        #1;
        while (stallE && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        if (stalls >= 100) begin
            checks++;
            errors++;
            $display("FAIL timeout: stallE still high after %0d cycles, required low", stalls);
        end
        startE = 1'b0;
        @(negedge clk);
        #1;
    endtask

    int stalls;

    initial begin
        // {op, a, b, expHi, expLo, expStall}
        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 3};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{3'd3, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 33};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[5]  = '{3'd3, 32'd17,       32'd5,        32'd2,        32'd3,        33};
        vecs[6]  = '{3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 3};
        vecs[7]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 3};
        vecs[8]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{3'd3, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 33};
        vecs[10] = '{3'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 33};
        vecs[11] = '{3'd2, 32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[12] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 3};

        rst    = 1'b1;
        startE = 1'b0;
        opE    = 3'd0;
        srcaE  = '0;
        srcbE  = '0;
        flushE = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset stallE", {31'b0, stallE}, 32'h0);

        // Table-driven arithmetic vectors
        for (int i = 0; i < 13; i++) begin
            doOp(vecs[i].op, vecs[i].a, vecs[i].b, stalls);
            chk($sformatf("vec%0d stall", i), 32'(stalls), 32'(vecs[i].expStall));
            chk($sformatf("vec%0d hi", i), hi, vecs[i].expHi);
            chk($sformatf("vec%0d lo", i), lo, vecs[i].expLo);
            chk($sformatf("vec%0d busy", i), {31'b0, busy}, 32'h0);
        end

        // MTHI / MTLO: no stall, visible next cycle
        @(negedge clk);
        startE = 1'b1; opE = 3'd4; srcaE = 32'h1234;
        #1;
        chk("mthi stallE", {31'b0, stallE}, 32'h0);
        @(negedge clk);
        opE = 3'd5; srcaE = 32'h5678;
        #1;
        chk("mthi hi", hi, 32'h1234);
        @(negedge clk);
        startE = 1'b0;
        #1;
        chk("mtlo lo", lo, 32'h5678);
        chk("mtlo busy", {31'b0, busy}, 32'h0);

        // DIVU 17/5 flushed in busy cycle 10
        @(negedge clk);
        startE = 1'b1; opE = 3'd3; srcaE = 32'd17; srcbE = 32'd5;
        repeat (10) @(negedge clk);
        #1;
        chk("flush pre stallE", {31'b0, stallE}, 32'h1);
        chk("flush pre busy", {31'b0, busy}, 32'h1);
        flushE = 1'b1;
        #1;
        chk("flush same-cycle stallE", {31'b0, stallE}, 32'h0);
        @(negedge clk);
        flushE = 1'b0; startE = 1'b0;
        #1;
        chk("flush next stallE", {31'b0, stallE}, 32'h0);
        chk("flush next busy", {31'b0, busy}, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("flush hi kept", hi, 32'h1234);
        chk("flush lo kept", lo, 32'h5678);

        // Rerun unflushed
        doOp(3'd3, 32'd17, 32'd5, stalls);
        chk("rerun stall", 32'(stalls), 32'd33);
        chk("rerun hi", hi, 32'd2);
        chk("rerun lo", lo, 32'd3);

        // Ops 6 and 7 have no effect
        for (int op = 6; op < 8; op++) begin
            @(negedge clk);
            startE = 1'b1; opE = 3'(op); srcaE = 32'hDEAD; srcbE = 32'h3;
            #1;
            chk($sformatf("op%0d stallE", op), {31'b0, stallE}, 32'h0);
            @(negedge clk);
            startE = 1'b0;
            #1;
            chk($sformatf("op%0d busy", op), {31'b0, busy}, 32'h0);
            chk($sformatf("op%0d hi", op), hi, 32'd2);
            chk($sformatf("op%0d lo", op), lo, 32'd3);
        end

        // flushE in IDLE blocks a multiply start and an MTHI
        @(negedge clk);
        startE = 1'b1; flushE = 1'b1; opE = 3'd0; srcaE = 32'd9; srcbE = 32'd9;
        #1;
        chk("idle flush stallE", {31'b0, stallE}, 32'h0);
        @(negedge clk);
        opE = 3'd4; srcaE = 32'hAAAA;
        #1;
        chk("idle flush busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        startE = 1'b0; flushE = 1'b0;
        #1;
        chk("idle flush hi", hi, 32'd2);
        chk("idle flush lo", lo, 32'd3);

        // flushE in DONE suppresses the HI/LO write
        @(negedge clk);
        startE = 1'b1; opE = 3'd0; srcaE = 32'd3; srcbE = 32'd4;
        stalls = 0;
        #1;
        while (stallE && stalls < 100) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        chk("done-flush stall", 32'(stalls), 32'd3);
        chk("done-flush busy in DONE", {31'b0, busy}, 32'h1);
        flushE = 1'b1;
        @(negedge clk);
        flushE = 1'b0; startE = 1'b0;
        #1;
        chk("done-flush busy", {31'b0, busy}, 32'h0);
        chk("done-flush hi", hi, 32'd2);
        chk("done-flush lo", lo, 32'd3);

        // Reset mid-operation
        @(negedge clk);
        startE = 1'b1; opE = 3'd2; srcaE = 32'd50; srcbE = 32'd7;
        repeat (4) @(negedge clk);
        startE = 1'b0;
        #1;
        chk("rst-mid busy before", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst-mid busy", {31'b0, busy}, 32'h0);
        chk("rst-mid stallE", {31'b0, stallE}, 32'h0);
        chk("rst-mid hi", hi, 32'h0);
        chk("rst-mid lo", lo, 32'h0);
        repeat (40) @(negedge clk);
        #1;
        chk("rst-mid lo later", lo, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
